// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline stage buffers and pipe_hazard_ctrl.
// master = the controller end, slave = the pipeline/buffer end.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             MemRead_E;
    logic [4:0]       Rd_E;
    logic [4:0]       Rs1_D;
    logic [4:0]       Rs2_D;
    logic             reg_ren_D;
    logic             redirect_E;
    logic             imem_ack;
    logic             dmem_req_M;
    logic             dmem_ack;
    logic             ebreak_W;
    logic             valid_F;
    logic             valid_D;
    logic             valid_E;
    logic             valid_M;
    logic             bubble_D;
    logic             bubble_E;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  MemRead_E, Rd_E, Rs1_D, Rs2_D, reg_ren_D, redirect_E,
               imem_ack, dmem_req_M, dmem_ack, ebreak_W,
        output valid_F, valid_D, valid_E, valid_M, bubble_D, bubble_E,
               halted, mem_err, stall_cycles
    );

    modport slave (
        output MemRead_E, Rd_E, Rs1_D, Rs2_D, reg_ren_D, redirect_E,
               imem_ack, dmem_req_M, dmem_ack, ebreak_W,
        input  valid_F, valid_D, valid_E, valid_M, bubble_D, bubble_E,
               halted, mem_err, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stage capture enables, bubble strobes, data-memory
// wait/timeout tracking, ebreak halt and a stall-cycle performance counter.
//
// state    | meaning
// RUN      | normal issue, hazards resolved combinationally
// MEM_WAIT | data access outstanding, pipe frozen, timeout counting
// HALT     | stopped by ebreak, leave only through reset
// ERROR    | data access timed out, leave only through reset
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_hazard_ctrl_if.master   hz
);

    localparam int TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] HALT     = 2'd2;
    localparam logic [1:0] ERROR    = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [TO_W-1:0] to_cnt_inc;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic active;
    logic dstall;
    logic lu;
    logic v_f, v_d, v_e, v_m, b_d, b_e;

    assign active = (state_q == RUN) || (state_q == MEM_WAIT);
    assign dstall = hz.dmem_req_M & ~hz.dmem_ack;
    assign lu     = hz.MemRead_E & hz.reg_ren_D & (hz.Rd_E != 5'd0) &
                    ((hz.Rd_E == hz.Rs1_D) | (hz.Rd_E == hz.Rs2_D));

    // rst_n gates the enables so buffers never capture while reset is held
    always_comb begin
        v_f = 1'b0;
        v_d = 1'b0;
        v_e = 1'b0;
        v_m = 1'b0;
        b_d = 1'b0;
        b_e = 1'b0;
        if (rst_n && active) begin
            if (hz.ebreak_W || dstall) begin
                v_f = 1'b0;
            end else if (hz.redirect_E) begin
                {v_f, v_d, v_e, v_m} = 4'b1111;
                b_d = 1'b1;
                b_e = 1'b1;
            end else if (lu) begin
                v_e = 1'b1;
                v_m = 1'b1;
                b_e = 1'b1;
            end else if (!hz.imem_ack) begin
                v_d = 1'b1;
                v_e = 1'b1;
                v_m = 1'b1;
                b_d = 1'b1;
            end else begin
                {v_f, v_d, v_e, v_m} = 4'b1111;
            end
        end
    end

    assign to_cnt_inc = to_cnt_q + TO_W'(1);

    // The counter holds the number of frozen cycles seen so far, including the
    // current one once incremented; reaching MEM_TIMEOUT means the limit is spent.
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        case (state_q)
            RUN: begin
                if (hz.ebreak_W) begin
                    state_d = HALT;
                end else if (dstall) begin
                    state_d  = (MEM_TIMEOUT <= 1) ? ERROR : MEM_WAIT;
                    to_cnt_d = TO_W'(1);
                end
            end
            MEM_WAIT: begin
                if (hz.ebreak_W) begin
                    state_d  = HALT;
                    to_cnt_d = '0;
                end else if (dstall) begin
                    if (to_cnt_inc == TO_W'(MEM_TIMEOUT)) begin
                        state_d = ERROR;
                    end
                    to_cnt_d = to_cnt_inc;
                end else begin
                    state_d  = RUN;
                    to_cnt_d = '0;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (active && !v_f) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            to_cnt_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            stall_q  <= stall_d;
        end
    end

    assign hz.valid_F      = v_f;
    assign hz.valid_D      = v_d;
    assign hz.valid_E      = v_e;
    assign hz.valid_M      = v_m;
    assign hz.bubble_D     = b_d;
    assign hz.bubble_E     = b_e;
    assign hz.halted       = (state_q == HALT);
    assign hz.mem_err      = (state_q == ERROR);
    assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised plus directed bench for pipe_hazard_ctrl with a queue scoreboard
// fed by an abstract model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int TO    = 4;
    localparam int CNT_W = 32;

    typedef struct packed {
        logic       rst_n;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       ren;
        logic       redir;
        logic       iack;
        logic       dreq;
        logic       dack;
        logic       ebrk;
    } stim_t;

    typedef struct packed {
        logic [5:0]  vb;
        logic        halted;
        logic        err;
        logic [31:0] stalls;
    } exp_t;

    logic clk;
    logic rst_n;
    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // model: halted / error flags, consecutive frozen-wait cycles, stall total
    bit          m_halt;
    bit          m_err;
    int          m_wait;
    logic [31:0] m_stalls;

    function automatic stim_t idle();
        stim_t s;
        s       = '0;
        s.rst_n = 1'b1;
        s.iack  = 1'b1;
        return s;
    endfunction

    // {valid_F, valid_D, valid_E, valid_M, bubble_D, bubble_E}
    function automatic logic [5:0] decide(stim_t s);
        bit ds, lu;
        if (!s.rst_n || m_halt || m_err) return 6'b000000;
        ds = s.dreq && !s.dack;
        lu = s.mr && s.ren && (s.rd != 0) && (s.rd == s.rs1 || s.rd == s.rs2);
        if (s.ebrk)   return 6'b000000;
        if (ds)       return 6'b000000;
        if (s.redir)  return 6'b111111;
        if (lu)       return 6'b001101;
        if (!s.iack)  return 6'b011110;
        return 6'b111100;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst_n         = s.rst_n;
        hz.MemRead_E  = s.mr;
        hz.Rd_E       = s.rd;
        hz.Rs1_D      = s.rs1;
        hz.Rs2_D      = s.rs2;
        hz.reg_ren_D  = s.ren;
        hz.redirect_E = s.redir;
        hz.imem_ack   = s.iack;
        hz.dmem_req_M = s.dreq;
        hz.dmem_ack   = s.dack;
        hz.ebreak_W   = s.ebrk;
        if (!s.rst_n) begin
            m_halt   = 0;
            m_err    = 0;
            m_wait   = 0;
            m_stalls = '0;
        end
        e.vb     = decide(s);
        e.halted = m_halt;
        e.err    = m_err;
        e.stalls = m_stalls;
        exp_q.push_back(e);
        if (s.rst_n && !m_halt && !m_err) begin
            if (!e.vb[5]) m_stalls = m_stalls + 1;
            if (s.ebrk) begin
                m_halt = 1;
            end else if (s.dreq && !s.dack) begin
                m_wait = m_wait + 1;
                if (m_wait >= TO) m_err = 1;
            end else begin
                m_wait = 0;
            end
        end
    endtask

    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // monitor: outputs are combinational, so every cycle presents a response
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare("valids_bubbles",
                        32'({hz.valid_F, hz.valid_D, hz.valid_E, hz.valid_M, hz.bubble_D, hz.bubble_E}),
                        32'(e.vb));
                compare("halted", 32'(hz.halted), 32'(e.halted));
                compare("mem_err", 32'(hz.mem_err), 32'(e.err));
                compare("stall_cycles", hz.stall_cycles, e.stalls);
            end
        end
    end

    initial begin
        stim_t s;
        int    dead;
        rst_n         = 1'b0;
        hz.MemRead_E  = 1'b0;
        hz.Rd_E       = '0;
        hz.Rs1_D      = '0;
        hz.Rs2_D      = '0;
        hz.reg_ren_D  = 1'b0;
        hz.redirect_E = 1'b0;
        hz.imem_ack   = 1'b0;
        hz.dmem_req_M = 1'b0;
        hz.dmem_ack   = 1'b0;
        hz.ebreak_W   = 1'b0;
        m_halt = 0; m_err = 0; m_wait = 0; m_stalls = '0;

        s = idle(); s.rst_n = 1'b0;
        step(s); step(s);
        step(idle());

        // load-use, then the same with x0 destination
        s = idle(); s.mr = 1; s.rd = 5; s.rs1 = 5; s.ren = 1;
        step(s);
        step(idle());
        s.rd = 0; s.rs1 = 0;
        step(s);
        // redirect squashes a load-use
        s = idle(); s.mr = 1; s.rd = 5; s.rs1 = 5; s.ren = 1; s.redir = 1;
        step(s);
        // instruction fetch wait
        s = idle(); s.iack = 0;
        step(s);

        // data wait of three cycles then ack
        s = idle(); s.dreq = 1;
        repeat (3) step(s);
        s.dack = 1;
        step(s);
        step(idle());

        // timeout into ERROR, sticky through a later ack
        s = idle(); s.dreq = 1;
        repeat (6) step(s);
        s.dack = 1;
        repeat (2) step(s);
        s = idle(); s.rst_n = 0;
        step(s);
        step(idle());

        // ebreak beats dstall and redirect
        s = idle(); s.ebrk = 1; s.dreq = 1; s.redir = 1;
        step(s);
        s = idle(); s.iack = 0;
        repeat (3) step(s);
        s = idle(); s.rst_n = 0;
        step(s);
        step(idle());

        // reset dropped in the middle of a data wait
        s = idle(); s.dreq = 1;
        repeat (2) step(s);
        s.rst_n = 0;
        step(s);
        step(idle());
        step(idle());

        dead = 0;
        for (int i = 0; i < 600; i++) begin
            s       = idle();
            s.mr    = ($urandom_range(0, 2) == 0);
            s.rd    = 5'($urandom_range(0, 5));
            s.rs1   = 5'($urandom_range(0, 5));
            s.rs2   = 5'($urandom_range(0, 5));
            s.ren   = ($urandom_range(0, 3) != 0);
            s.redir = ($urandom_range(0, 7) == 0);
            s.iack  = ($urandom_range(0, 3) != 0);
            s.dreq  = ($urandom_range(0, 3) == 0);
            s.dack  = ($urandom_range(0, 2) == 0);
            s.ebrk  = ($urandom_range(0, 99) == 0);
            if (m_halt || m_err) dead = dead + 1;
            if (dead > 3) begin
                s.rst_n = 1'b0;
                dead    = 0;
            end
            step(s);
        end

        @(negedge clk);
        #5;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Produces the per-stage capture enables (valid_F/D/E/M) and bubble-insert strobes consumed by the F->D, D->E, E->M and M->W stage buffers.
- It is the controlling end of the buffers' valid interface. It resolves load-use hazards, taken-branch/jump redirects, instruction- and data-memory wait states, and ebreak halt.
- Holds a small state machine, a data-memory timeout counter and a stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 255, max consecutive cycles a data access may wait for dmem_ack before ERROR
CNT_W, 32, width of stall_cycles counter

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
MemRead_E  input  1  instruction in E is a load
Rd_E  input  5  destination register of instruction in E
Rs1_D  input  5  source register 1 of instruction in D
Rs2_D  input  5  source register 2 of instruction in D
reg_ren_D  input  1  instruction in D reads registers
redirect_E  input  1  taken branch or jal resolved in E this cycle
imem_ack  input  1  instruction fetch data valid this cycle
dmem_req_M  input  1  instruction in M is a load or store
dmem_ack  input  1  data memory completes M access this cycle
ebreak_W  input  1  ebreak in W
valid_F  output  1  PC register update enable
valid_D  output  1  F->D buffer capture enable
valid_E  output  1  D->E buffer capture enable
valid_M  output  1  E->M and M->W buffer capture enable
bubble_D  output  1  F->D buffer captures a NOP (instr 0x00000013) instead of instr_F
bubble_E  output  1  D->E buffer captures all-zero control signals
halted  output  1  core stopped by ebreak
mem_err  output  1  data access timed out
stall_cycles  output  CNT_W  count of cycles with valid_F=0 while RUN/MEM_WAIT

Behaviour:
- Reset (rst_n low, async): state=RUN, timeout counter=0, stall_cycles=0, halted=0, mem_err=0. All valids and bubbles are 0 while rst_n is low.
- Enable/bubble outputs are combinational from state and inputs, so they act in the same cycle. State and counters update on posedge clk.
- States: RUN, MEM_WAIT, HALT, ERROR.
- Stall conditions:
  - dstall = dmem_req_M & ~dmem_ack.
  - lu = MemRead_E & reg_ren_D & (Rd_E!=0) & (Rd_E==Rs1_D | Rd_E==Rs2_D).
- Decision priority in RUN/MEM_WAIT, first match wins:
  1. ebreak_W: all valids 0, bubbles 0; next state HALT.
  2. dstall: all valids 0, bubbles 0 (whole pipe frozen).
  3. redirect_E: valid_F=valid_D=valid_E=valid_M=1, bubble_D=1, bubble_E=1. Redirect squashes any load-use in D.
  4. lu: valid_F=0, valid_D=0, valid_E=1, bubble_E=1, valid_M=1.
  5. ~imem_ack: valid_F=0, valid_D=1, bubble_D=1, valid_E=valid_M=1.
  6. Otherwise all valids 1, bubbles 0.
- RUN -> MEM_WAIT when dstall and not ebreak_W; counter cleared to 1.
- MEM_WAIT:
  - counter increments each dstall cycle.
  - dmem_ack -> RUN with counter=0.
  - dstall with counter==MEM_TIMEOUT -> ERROR.
- HALT: all valids 0, bubbles 0, halted=1. Exit only by reset.
- ERROR: as HALT but mem_err=1, halted=0. Exit only by reset.
- stall_cycles increments (wrapping at 2^CNT_W) on each clock where state is RUN or MEM_WAIT and valid_F=0. It does not count in HALT or ERROR.
- A redirect coinciding with dstall is not lost: E is frozen, so redirect_E remains asserted on the next cycle.
- Reset mid-MEM_WAIT aborts the wait immediately; no residual count.

Test Plan:
- Load-use: MemRead_E=1, Rd_E=5, Rs1_D=5, reg_ren_D=1, others idle -> valid_F=0, valid_D=0, bubble_E=1, valid_E=valid_M=1 for exactly 1 cycle; stall_cycles 0->1. With Rd_E=0, the same stimulus gives all valids 1.
- Redirect over load-use: redirect_E=1 together with the load-use pattern above -> valid_F=1, bubble_D=1, bubble_E=1, all valids 1.
- Data wait: dmem_req_M=1, dmem_ack=0 for 3 cycles then 1 -> all valids 0 for 3 cycles. State is MEM_WAIT then RUN; valids return to 1 in the ack cycle; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, dmem_ack held 0 -> 4 frozen cycles, then state ERROR. mem_err=1 stays set through a later dmem_ack=1 until rst_n pulses low.
- Halt: ebreak_W=1 in the same cycle as dstall and redirect_E -> valids 0, next cycle halted=1; stall_cycles stops counting.
- Async reset mid-MEM_WAIT: drop rst_n between clock edges -> valids 0 and counters 0 immediately. After release with idle inputs, all valids are 1 on the first cycle.
